// File: rtl/fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch : IF stage - owns the PC, drives imem, loads the IF/ID register     |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INT0_VEC = 32'h0000_0002,
  parameter logic [31:0] INT1_VEC = 32'h0000_0004,
  parameter logic [4:0]  HALT_OP  = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        Branch,
  input  logic [31:0] BrPC,
  input  logic        intRet,
  input  logic [1:0]  Interrupt,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic [31:0] inst,
  output logic [31:0] pcOut,
  output logic        instValid,
  output logic        intValid,
  output logic [31:0] retPC,
  output logic [1:0]  intAck
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_ISR  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pcOut;
  logic        r_instValid;
  logic        r_intValid;
  logic [31:0] r_retPC;
  logic [1:0]  r_intAck;

  logic        w_isHalt;
  logic        w_intAccept;
  logic [1:0]  w_intSel;
  logic [31:0] w_intVec;
  logic [31:0] w_pcInc;

  assign w_isHalt    = (imemData[31:27] == HALT_OP);
  assign w_intAccept = (r_state != S_ISR) && (Interrupt != 2'b00);
  // Line 0 wins when both requests are raised together.
  assign w_intSel    = Interrupt[0] ? 2'b01 : 2'b10;
  assign w_intVec    = Interrupt[0] ? INT0_VEC : INT1_VEC;
  assign w_pcInc     = r_pc + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_pcOut     <= 32'd0;
      r_instValid <= 1'b0;
      r_intValid  <= 1'b0;
      r_retPC     <= 32'd0;
      r_intAck    <= 2'b00;
    end else begin
      r_intAck <= 2'b00;
      if (!stall) begin
        if (Branch) begin
          r_pc        <= BrPC;
          r_inst      <= 32'd0;
          r_pcOut     <= r_pc;
          r_instValid <= 1'b0;
          r_intValid  <= 1'b0;
          r_retPC     <= 32'd0;
          if (r_state == S_HALT) r_state <= S_RUN;
        end else if (w_intAccept) begin
          // Marker bubble carries the not-yet-executed PC as return address.
          r_pc        <= w_intVec;
          r_inst      <= 32'd0;
          r_pcOut     <= r_pc;
          r_instValid <= 1'b0;
          r_intValid  <= 1'b1;
          r_retPC     <= r_pc;
          r_intAck    <= w_intSel;
          r_state     <= S_ISR;
        end else begin
          case (r_state)
            S_HALT: begin
              r_inst      <= 32'd0;
              r_pcOut     <= r_pc;
              r_instValid <= 1'b0;
              r_intValid  <= 1'b0;
              r_retPC     <= 32'd0;
            end
            S_ISR: begin
              r_inst      <= imemData;
              r_pcOut     <= r_pc;
              r_instValid <= 1'b1;
              r_intValid  <= 1'b0;
              r_retPC     <= 32'd0;
              r_pc        <= w_pcInc;
              if (intRet) r_state <= S_RUN;
            end
            default: begin
              // HALT still advances the PC once, so it parks on the next word.
              r_inst      <= imemData;
              r_pcOut     <= r_pc;
              r_instValid <= 1'b1;
              r_intValid  <= 1'b0;
              r_retPC     <= 32'd0;
              r_pc        <= w_pcInc;
              r_state     <= w_isHalt ? S_HALT : S_RUN;
            end
          endcase
        end
      end
    end
  end

  assign imemAddr  = r_pc;
  assign inst      = r_inst;
  assign pcOut     = r_pcOut;
  assign instValid = r_instValid;
  assign intValid  = r_intValid;
  assign retPC     = r_retPC;
  assign intAck    = r_intAck;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch : directed scoreboard bench for the fetch stage                  |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        Branch;
  logic [31:0] BrPC;
  logic        intRet;
  logic [1:0]  Interrupt;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] inst;
  logic [31:0] pcOut;
  logic        instValid;
  logic        intValid;
  logic [31:0] retPC;
  logic [1:0]  intAck;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        iv;
    logic        intv;
    logic [31:0] ret;
    logic [1:0]  ack;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];

  fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .Branch(Branch), .BrPC(BrPC),
    .intRet(intRet), .Interrupt(Interrupt), .imemAddr(imemAddr),
    .imemData(imemData), .inst(inst), .pcOut(pcOut), .instValid(instValid),
    .intValid(intValid), .retPC(retPC), .intAck(intAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: address 20 holds HALT, others are address-tagged words.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd20) return 32'hF800_0014;
    return {5'b00001, a[26:0]};
  endfunction

  assign imemData = mem(imemAddr);

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "inst", inst, e.inst);
      chk(e.nm, "pcOut", pcOut, e.pc);
      chk(e.nm, "instValid", {31'd0, instValid}, {31'd0, e.iv});
      chk(e.nm, "intValid", {31'd0, intValid}, {31'd0, e.intv});
      chk(e.nm, "retPC", retPC, e.ret);
      chk(e.nm, "intAck", {30'd0, intAck}, {30'd0, e.ack});
      chk(e.nm, "imemAddr", imemAddr, e.addr);
    end
  end

  // Drives inputs for the next rising edge and queues the expected post-edge state.
  task automatic cyc(input string nm, input logic st, input logic br, input logic [31:0] bpc,
                     input logic [1:0] irq, input logic iret,
                     input logic [31:0] ei, input logic [31:0] ep, input logic eiv,
                     input logic eintv, input logic [31:0] eret, input logic [1:0] eack,
                     input logic [31:0] eaddr);
    exp_t e;
    @(negedge clk);
    stall     = st;
    Branch    = br;
    BrPC      = bpc;
    Interrupt = irq;
    intRet    = iret;
    e.nm = nm; e.inst = ei; e.pc = ep; e.iv = eiv; e.intv = eintv;
    e.ret = eret; e.ack = eack; e.addr = eaddr;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; Branch = 1'b0; BrPC = 32'd0;
    intRet = 1'b0; Interrupt = 2'b00;

    cyc("reset", 0, 0, 0, 2'b00, 0, 32'd0, 32'd0, 0, 0, 32'd0, 2'b00, 32'd0);
    #3 rst_n = 1'b1;

    cyc("f0", 0, 0, 0, 2'b00, 0, mem(0), 32'd0, 1, 0, 32'd0, 2'b00, 32'd1);
    cyc("f1", 0, 0, 0, 2'b00, 0, mem(1), 32'd1, 1, 0, 32'd0, 2'b00, 32'd2);
    cyc("f2", 0, 0, 0, 2'b00, 0, mem(2), 32'd2, 1, 0, 32'd0, 2'b00, 32'd3);
    cyc("f3", 0, 0, 0, 2'b00, 0, mem(3), 32'd3, 1, 0, 32'd0, 2'b00, 32'd4);
    cyc("f4", 0, 0, 0, 2'b00, 0, mem(4), 32'd4, 1, 0, 32'd0, 2'b00, 32'd5);

    for (int i = 0; i < 3; i++)
      cyc("stall", 1, 0, 0, 2'b00, 0, mem(4), 32'd4, 1, 0, 32'd0, 2'b00, 32'd5);
    cyc("f5", 0, 0, 0, 2'b00, 0, mem(5), 32'd5, 1, 0, 32'd0, 2'b00, 32'd6);
    cyc("f6", 0, 0, 0, 2'b00, 0, mem(6), 32'd6, 1, 0, 32'd0, 2'b00, 32'd7);
    cyc("f7", 0, 0, 0, 2'b00, 0, mem(7), 32'd7, 1, 0, 32'd0, 2'b00, 32'd8);

    cyc("br40", 0, 1, 32'h40, 2'b00, 0, 32'd0, 32'd8, 0, 0, 32'd0, 2'b00, 32'h40);
    cyc("f40", 0, 0, 0, 2'b00, 0, mem(32'h40), 32'h40, 1, 0, 32'd0, 2'b00, 32'h41);
    cyc("br10", 0, 1, 32'd10, 2'b00, 0, 32'd0, 32'h41, 0, 0, 32'd0, 2'b00, 32'd10);

    cyc("irq11", 0, 0, 0, 2'b11, 0, 32'd0, 32'd10, 0, 1, 32'd10, 2'b01, 32'd2);
    cyc("isr2", 0, 0, 0, 2'b10, 0, mem(2), 32'd2, 1, 0, 32'd0, 2'b00, 32'd3);
    cyc("isr3", 0, 0, 0, 2'b10, 0, mem(3), 32'd3, 1, 0, 32'd0, 2'b00, 32'd4);
    cyc("iret", 0, 0, 0, 2'b10, 1, mem(4), 32'd4, 1, 0, 32'd0, 2'b00, 32'd5);
    cyc("irq1", 0, 0, 0, 2'b10, 0, 32'd0, 32'd5, 0, 1, 32'd5, 2'b10, 32'd4);
    cyc("isr4", 0, 0, 0, 2'b00, 0, mem(4), 32'd4, 1, 0, 32'd0, 2'b00, 32'd5);
    cyc("iret2", 0, 0, 0, 2'b00, 1, mem(5), 32'd5, 1, 0, 32'd0, 2'b00, 32'd6);

    cyc("br20", 0, 1, 32'd20, 2'b00, 0, 32'd0, 32'd6, 0, 0, 32'd0, 2'b00, 32'd20);
    cyc("halt", 0, 0, 0, 2'b00, 0, 32'hF800_0014, 32'd20, 1, 0, 32'd0, 2'b00, 32'd21);
    cyc("hb0", 0, 0, 0, 2'b00, 0, 32'd0, 32'd21, 0, 0, 32'd0, 2'b00, 32'd21);
    cyc("hb1", 0, 0, 0, 2'b00, 0, 32'd0, 32'd21, 0, 0, 32'd0, 2'b00, 32'd21);
    cyc("hirq", 0, 0, 0, 2'b10, 0, 32'd0, 32'd21, 0, 1, 32'd21, 2'b10, 32'd4);
    cyc("hisr", 0, 0, 0, 2'b00, 0, mem(4), 32'd4, 1, 0, 32'd0, 2'b00, 32'd5);
    cyc("hiret", 0, 0, 0, 2'b00, 1, mem(5), 32'd5, 1, 0, 32'd0, 2'b00, 32'd6);

    cyc("brirq", 0, 1, 32'h30, 2'b01, 0, 32'd0, 32'd6, 0, 0, 32'd0, 2'b00, 32'h30);
    cyc("defirq", 0, 0, 0, 2'b01, 0, 32'd0, 32'h30, 0, 1, 32'h30, 2'b01, 32'd2);
    cyc("brwrap", 0, 1, 32'hFFFF_FFFF, 2'b00, 0, 32'd0, 32'd2, 0, 0, 32'd0, 2'b00, 32'hFFFF_FFFF);
    cyc("fwrap", 0, 0, 0, 2'b00, 0, mem(32'hFFFF_FFFF), 32'hFFFF_FFFF, 1, 0, 32'd0, 2'b00, 32'd0);
    cyc("f0b", 0, 0, 0, 2'b00, 1, mem(0), 32'd0, 1, 0, 32'd0, 2'b00, 32'd1);
    cyc("irq0b", 0, 0, 0, 2'b01, 0, 32'd0, 32'd1, 0, 1, 32'd1, 2'b01, 32'd2);
    cyc("stallack", 1, 0, 0, 2'b00, 0, 32'd0, 32'd1, 0, 1, 32'd1, 2'b00, 32'd2);

    // Asynchronous reset mid-ISR must clear outputs without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    chk("areset", "inst", inst, 32'd0);
    chk("areset", "pcOut", pcOut, 32'd0);
    chk("areset", "intValid", {31'd0, intValid}, 32'd0);
    chk("areset", "retPC", retPC, 32'd0);
    chk("areset", "imemAddr", imemAddr, 32'd0);

    @(posedge clk);
    #2;
    chk("drain", "queue", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
